alu_acc_sequencer: RTL
======================

Name: alu_acc_sequencer

Overview:
- Downstream consumer and controller of the 8-bit ripple/CLA adder. Accepts an operation from the control unit, drives the adder's en/A/B/c_in, waits for its ready, then commits Output/c_out into the accumulator and the flag register.
- Provides the accumulator (ACC) and the C/Z/N/V flags to the rest of the 8-bit datapath.

Parameters:
- WIDTH, 8, datapath width; must match the adder.
- TIMEOUT, 16, maximum WAIT cycles for add_ready before the operation aborts. Range 2..255.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  operation: 00 LOAD, 01 ADD, 10 ADDC, 11 CLR.
- operand  in  WIDTH  B operand or LOAD value; sampled with start.
- add_en  out  1  adder enable.
- add_a  out  WIDTH  adder A (= ACC).
- add_b  out  WIDTH  adder B.
- add_cin  out  1  adder carry-in.
- add_out  in  WIDTH  adder result.
- add_cout  in  1  adder carry-out.
- add_ready  in  1  adder result valid.
- acc  out  WIDTH  accumulator.
- flag_c, flag_z, flag_n, flag_v  out  1 each  carry, zero, negative, signed overflow.
- busy  out  1  high in WAIT and DRAIN.
- done  out  1  one-cycle pulse when an operation completes or aborts.
- err  out  1  set on timeout; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. acc=0, all flags=0, add_en=0, add_a=0, add_b=0, add_cin=0, busy=0, done=0, err=0, timeout counter=0. Takes effect immediately, including mid-operation. No commit occurs.
- Registered outputs only. done defaults to 0 each cycle.
- States: IDLE, WAIT, DRAIN.
- IDLE + start + op=LOAD: next edge acc=operand, Z/N updated, V=0, C unchanged, done=1, err=0. Stays IDLE. Latency 1.
- IDLE + start + op=CLR: next edge acc=0, Z=1, N=C=V=0, done=1, err=0. Latency 1.
- IDLE + start + op=ADD/ADDC: next edge add_en=1, add_a=acc, add_b=operand, add_cin=0 (ADD) or flag_c (ADDC), err=0, counter=0, state goes to WAIT.
- WAIT: add_en and add_a/add_b/add_cin stay stable. Each edge samples add_ready.
  - add_ready=1: acc=add_out, C=add_cout, Z=(add_out==0), N=add_out[WIDTH-1], V=(a_msb==b_msb)&&(add_out msb!=a_msb). Also add_en=0, done=1, state goes to DRAIN.
  - add_ready=0: counter++. When the counter reaches TIMEOUT-1 with ready still low: add_en=0, err=1, done=1, acc and flags unchanged, state goes to DRAIN.
- DRAIN: add_en=0. Returns to IDLE on the first edge that samples add_ready=0. This ensures a stale ready is never consumed by the next op.
- start while busy is ignored; it is neither queued nor flagged.
- Adder latency ≥1 cycle after add_en rises. Best-case ADD completes (done) 2 edges after start and returns to IDLE 1 edge later.
- Arithmetic is modulo 2^WIDTH. The carry-out comes solely from add_cout; the block does no internal addition.

Test Plan:
- Reset, LOAD 12, ADD 1 (adder ready after a few cycles) -> acc=13, C=0, Z=0, N=0, V=0. done pulses exactly once. add_en is high continuously from the edge after start until the commit edge.
- LOAD 0x7F, ADD 0x01 -> acc=0x80, N=1, V=1, C=0, Z=0.
- LOAD 0xFF, ADD 0x01 -> acc=0x00, Z=1, C=1, V=0. Then ADDC 0x00 -> add_cin=1, acc=0x01, C=0, Z=0.
- ADD with add_ready tied 0, TIMEOUT=16 -> after 16 WAIT cycles add_en=0, err=1, done pulse, acc unchanged. A subsequent LOAD 5 clears err and gives acc=5.
- Assert start with ADD while in WAIT -> ignored; only one done. Hold add_ready high 3 cycles after commit -> stays in DRAIN, busy=1, until ready falls.
- Pull rst_n low mid-WAIT (asynchronously, between edges) -> add_en, acc, flags, busy, err all 0 immediately. After release, CLR -> Z=1, done pulse.

Source files
------------

// File: rtl/alu_acc_sequencer.sv
// Accumulator/flag sequencer that drives an external 8-bit adder through an
// en/ready handshake and commits its result into ACC and the C/Z/N/V flags.
module alu_acc_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cout,
    input  logic             add_ready,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int                CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_ADDC = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_n_q, flag_n_d;
    logic               flag_v_q, flag_v_d;
    logic               add_en_q, add_en_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        // NOTE: every _d starts from its _q (done from 0) so no path leaves a
        // signal unassigned; that is what keeps this block free of latches.
        state_d   = state_q;
        acc_d     = acc_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
        flag_v_d  = flag_v_q;
        add_en_d  = add_en_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    unique case (op)
                        OP_LOAD: begin
                            acc_d    = operand;
                            flag_z_d = (operand == '0);
                            flag_n_d = operand[WIDTH-1];
                            flag_v_d = 1'b0;
                            done_d   = 1'b1;
                        end
                        OP_CLR: begin
                            acc_d    = '0;
                            flag_c_d = 1'b0;
                            flag_z_d = 1'b1;
                            flag_n_d = 1'b0;
                            flag_v_d = 1'b0;
                            done_d   = 1'b1;
                        end
                        default: begin
                            add_en_d  = 1'b1;
                            add_a_d   = acc_q;
                            add_b_d   = operand;
                            add_cin_d = (op == OP_ADDC) ? flag_c_q : 1'b0;
                            cnt_d     = '0;
                            state_d   = S_WAIT;
                        end
                    endcase
                end
            end

            S_WAIT: begin
                if (add_ready) begin
                    acc_d    = add_out;
                    flag_c_d = add_cout;
                    flag_z_d = (add_out == '0);
                    flag_n_d = add_out[WIDTH-1];
                    // Signed overflow: like-signed operands, result sign differs.
                    flag_v_d = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                               (add_out[WIDTH-1] != add_a_q[WIDTH-1]);
                    add_en_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DRAIN;
                end else if (cnt_q == CNT_LAST) begin
                    add_en_d = 1'b0;
                    err_d    = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DRAIN: begin
                // Hold off the next op until a stale ready has gone away.
                add_en_d = 1'b0;
                if (!add_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                add_en_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            add_en_q  <= 1'b0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q   <= state_d;
            acc_q     <= acc_d;
            flag_c_q  <= flag_c_d;
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
            flag_v_q  <= flag_v_d;
            add_en_q  <= add_en_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign add_en  = add_en_q;
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign acc     = acc_q;
    assign flag_c  = flag_c_q;
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;
    assign flag_v  = flag_v_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
